// File: rtl/nto2n_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with an internal index register.
// The index is loaded, stepped, or auto-run at a programmable period; z tracks idx every cycle.
module nto2n_decoder_seq #(
  parameter int N  = 2,
  parameter int PW = 8,
  localparam int W = 1 << N
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [N-1:0]  idx_i,
  input  logic          step_i,
  input  logic          dir_i,
  input  logic          run_i,
  input  logic [PW-1:0] period_i,
  input  logic          en_i,
  output logic [W-1:0]  z_o,
  output logic [N-1:0]  idx_o,
  output logic          wrap_o
);

  logic [N-1:0]  idx_q, idx_d;
  logic [W-1:0]  z_q, z_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          do_step;

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    do_step = 1'b0;

    if (load_i) begin
      idx_d = idx_i;
      cnt_d = '0;
    end else if (run_i) begin
      // A period lowered below the running count restarts the count without stepping.
      if (cnt_q == period_i) begin
        do_step = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q > period_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end else begin
      cnt_d   = '0;
      do_step = step_i;
    end

    if (do_step) begin
      if (dir_i) begin
        idx_d  = idx_q - N'(1);
        wrap_d = (idx_q == '0);
      end else begin
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == {N{1'b1}});
      end
    end

    z_d = en_i ? ({{(W-1){1'b0}}, 1'b1} << idx_d) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      z_q    <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      z_q    <= z_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z_o    = z_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_nto2n_decoder_seq.sv
// Scoreboard bench for nto2n_decoder_seq: an N=2 and an N=3 instance share one stimulus stream,
// expected outputs are queued per cycle from a reference model and checked by a separate monitor.
module tb_nto2n_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld = 1'b0, stp = 1'b0, dir = 1'b0, run = 1'b0, en = 1'b0;
  logic [2:0] idx_in3 = '0;
  logic [7:0] period = '0;

  logic [3:0] z2;
  logic [1:0] idx2;
  logic       wrap2;
  logic [7:0] z3;
  logic [2:0] idx3;
  logic       wrap3;

  always #5 clk = ~clk;

  nto2n_decoder_seq #(.N(2), .PW(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .idx_i(idx_in3[1:0]), .step_i(stp),
    .dir_i(dir), .run_i(run), .period_i(period), .en_i(en),
    .z_o(z2), .idx_o(idx2), .wrap_o(wrap2)
  );

  nto2n_decoder_seq #(.N(3), .PW(8)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .idx_i(idx_in3), .step_i(stp),
    .dir_i(dir), .run_i(run), .period_i(period), .en_i(en),
    .z_o(z3), .idx_o(idx3), .wrap_o(wrap3)
  );

  typedef struct {
    int              idx;
    longint unsigned z;
    bit              wrap;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: index per instance width, shared period count.
  int m_idx2 = 0, m_idx3 = 0, m_cnt = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void apply_step(inout int idx, input int w, input bit d, output bit wr);
    if (!d) begin
      wr  = (idx == w - 1);
      idx = (idx + 1) % w;
    end else begin
      wr  = (idx == 0);
      idx = (idx + w - 1) % w;
    end
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what both instances must show after the next rising edge.
  task automatic drive(input bit l, input int ii, input bit s, input bit d,
                       input bit r, input int p, input bit e);
    bit   stepping;
    bit   wr2, wr3;
    exp_t x2, x3;
    @(negedge clk);
    rst_n   = 1'b1;
    ld      = l;
    idx_in3 = 3'(ii);
    stp     = s;
    dir     = d;
    run     = r;
    period  = 8'(p);
    en      = e;

    stepping = 1'b0;
    wr2 = 1'b0;
    wr3 = 1'b0;
    if (l) begin
      m_idx2 = ii % 4;
      m_idx3 = ii % 8;
      m_cnt  = 0;
    end else if (r) begin
      if (m_cnt == p) begin
        stepping = 1'b1;
        m_cnt    = 0;
      end else if (m_cnt > p) m_cnt = 0;
      else m_cnt++;
    end else begin
      m_cnt    = 0;
      stepping = s;
    end
    if (stepping) begin
      apply_step(m_idx2, 4, d, wr2);
      apply_step(m_idx3, 8, d, wr3);
    end

    x2.idx = m_idx2; x2.wrap = wr2; x2.z = e ? (64'd1 << m_idx2) : 64'd0;
    x3.idx = m_idx3; x3.wrap = wr3; x3.z = e ? (64'd1 << m_idx3) : 64'd0;
    q2.push_back(x2);
    q3.push_back(x3);
  endtask

  // Asserts reset mid-cycle and leaves it asserted; the next drive() releases it.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_z2", 64'(z2), 0);
    check("reset_idx2", 64'(idx2), 0);
    check("reset_wrap2", 64'(wrap2), 0);
    check("reset_z3", 64'(z3), 0);
    check("reset_idx3", 64'(idx3), 0);
    check("reset_wrap3", 64'(wrap3), 0);
    m_idx2 = 0;
    m_idx3 = 0;
    m_cnt  = 0;
  endtask

  initial begin : monitor
    exp_t e2, e3;
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() > 0 && q3.size() > 0) begin
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        check("n2_idx", 64'(idx2), 64'(e2.idx));
        check("n2_z", 64'(z2), e2.z);
        check("n2_wrap", 64'(wrap2), 64'(e2.wrap));
        check("n2_onehot", 64'($countones(z2) <= 1), 1);
        check("n3_idx", 64'(idx3), 64'(e3.idx));
        check("n3_z", 64'(z3), e3.z);
        check("n3_wrap", 64'(wrap3), 64'(e3.wrap));
        check("n3_onehot", 64'($countones(z3) <= 1), 1);
      end
    end
  end

  initial begin : stimulus
    int guard;
    repeat (3) @(posedge clk);
    do_reset();

    // release with en=1, idle: z shows index 0
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // loads
    drive(1, 2, 0, 0, 0, 0, 1);
    drive(1, 3, 0, 0, 0, 0, 1);
    // step up across 3->0 (N=2)
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // step down across 0->3 / 0->7
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    // N=3 wrap 7->0
    drive(1, 7, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 1);
    // auto-run period=2, then period=0
    drive(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 0, 1, 2, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 1, 1, 0, 1);
    // load beats step and run
    drive(1, 1, 1, 0, 1, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 1);
    // blanking while running, then unblank
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // period lowered below a running count
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 6, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 1, 1);
    // reset in the middle of a run
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 1, 1);
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < 500; i++)
      drive(($urandom_range(0, 7) == 0), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0));

    guard = 0;
    while ((q2.size() > 0 || q3.size() > 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q2.size() > 0 || q3.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q2.size() + q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
